sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1: extra access-strobe cycles, legal range 0..6.
REQ-002 SHALL have port Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port Reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  client request present.
REQ-005 SHALL have port req_ready  output  1  controller can accept a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  20  SRAM word address.
REQ-008 SHALL have port req_wdata  input  16  write data.
REQ-009 SHALL have port req_be  input  2  byte enables; [1] upper byte, [0] lower byte.
REQ-010 SHALL have port rdata  output  16  captured read data.
REQ-011 SHALL have port rdata_valid  output  1  one-cycle pulse; rdata valid.
REQ-012 SHALL have port SRAM_ADDR  output  20  address pins.
REQ-013 SHALL have ports SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  active-low SRAM controls.
REQ-014 SHALL have port Data_to_SRAM  output  16  write data toward the top-level DQ tristate.
REQ-015 SHALL have port Data_to_SRAM_oe  output  1  1 = top level drives DQ.
REQ-016 SHALL have port Data_from_SRAM  input  16  DQ pin value.

Function
REQ-017 SHALL use states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-018 SHALL assert req_ready only in IDLE; acceptance = req_valid && req_ready at a rising edge.
REQ-019 SHALL register addr, wdata, be, we at acceptance; SRAM_ADDR and Data_to_SRAM hold these until the next acceptance.
REQ-020 SHALL drive all SRAM_* and Data_to_SRAM_oe from flops, never combinationally from request inputs.
REQ-021 IDLE outputs SHALL be CE_N=OE_N=WE_N=UB_N=LB_N=1 and Data_to_SRAM_oe=0.
REQ-022 Read: SHALL move IDLE->RD at acceptance and stay in RD WAIT_CYCLES+1 cycles with CE_N=OE_N=UB_N=LB_N=0, WE_N=1, oe=0.
REQ-023 Read: SHALL capture Data_from_SRAM into rdata on the edge that leaves RD, return to IDLE on that same edge, and pulse rdata_valid for exactly the following cycle.
REQ-024 Read: rdata_valid SHALL go high WAIT_CYCLES+1 cycles after the acceptance edge; a new request MAY be accepted in the cycle rdata_valid is high.
REQ-025 Write: WR_SETUP SHALL last 1 cycle with CE_N=0, WE_N=1, OE_N=1, oe=1, UB_N=~be[1], LB_N=~be[0].
REQ-026 Write: WR_PULSE SHALL last WAIT_CYCLES+1 cycles with WE_N=0 and other signals as in WR_SETUP.
REQ-027 Write: WR_HOLD SHALL last 1 cycle with WE_N=1, oe=1, CE_N=0, and SHALL then return to IDLE; total write occupancy is WAIT_CYCLES+3 cycles.
REQ-028 A write with be=2'b00 SHALL follow the same state sequence and timing with WE_N held 1 throughout.
REQ-029 OE_N and WE_N SHALL never both be 0 in the same cycle; oe SHALL be 0 whenever OE_N=0.
REQ-030 The wait counter SHALL be 3 bits, load WAIT_CYCLES on entry to RD/WR_PULSE, decrement, and exit the state at zero.
REQ-031 req_valid while req_ready=0 SHALL be ignored; the client holds the request until accepted.

Reset
REQ-032 Reset_n low SHALL immediately force IDLE, the REQ-021 pin values, SRAM_ADDR=0, Data_to_SRAM=0, rdata=0, rdata_valid=0, counter=0.
REQ-033 Reset asserted mid-operation SHALL abort the access with no rdata_valid; the first acceptance SHALL be possible in the first cycle after release.

Structure
REQ-034 Package sram_pkg SHALL hold ADDR_W=20, DATA_W=16, and the state enum type.
REQ-035 No sub-module is needed; the DQ tristate SHALL live at the top level, not in this block.

Verification
REQ-036 With WAIT_CYCLES=1, read addr 0x12345 with Data_from_SRAM=0xBEEF -> OE_N low for 2 cycles, rdata=0xBEEF, rdata_valid high for 1 cycle, 2 cycles after acceptance.
REQ-037 Write 0x00010, data 0xA5A5, be=2'b11 -> setup 1, WE_N low 2, hold 1 cycle; oe high for 4 cycles; req_ready returns after 4 cycles.
REQ-038 Write with be=2'b10 -> UB_N=0 and LB_N=1 during the write; be=2'b00 -> WE_N never low, same 4-cycle occupancy.
REQ-039 Read held valid back-to-back with write -> write accepted in the rdata_valid cycle; no cycle has OE_N=0 and WE_N=0 together.
REQ-040 Reset_n pulsed low during WR_PULSE -> WE_N=1 and oe=0 asynchronously, no further strobes, req_ready=1 after release.
REQ-041 WAIT_CYCLES=0 and 6 -> read latency 1 and 7 cycles, write occupancy 3 and 9 cycles.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared widths and state encoding for the SRAM controller
package sram_pkg;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port async SRAM controller with registered pin timing
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_be,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic [DATA_W-1:0] Data_to_SRAM,
    output logic              Data_to_SRAM_oe,
    input  logic [DATA_W-1:0] Data_from_SRAM
);
    localparam logic [2:0] WC = 3'(WAIT_CYCLES);

    state_t     state, nxt;
    logic [2:0] cnt, cnt_nxt;
    logic [1:0] be_q, be_nxt;
    logic       acc, wr_nxt;

    assign req_ready = state == IDLE;
    assign acc       = req_valid && req_ready;
    assign be_nxt    = acc ? req_be : be_q;
    assign wr_nxt    = nxt == WR_SETUP || nxt == WR_PULSE || nxt == WR_HOLD;

    // next-state and wait-counter logic; strobe states exit when the counter hits zero
    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            IDLE: if (acc) begin
                nxt     = req_we ? WR_SETUP : RD;
                cnt_nxt = req_we ? 3'd0 : WC;
            end
            RD: if (cnt == 3'd0) nxt = IDLE; else cnt_nxt = cnt - 3'd1;
            WR_SETUP: begin
                nxt     = WR_PULSE;
                cnt_nxt = WC;
            end
            WR_PULSE: if (cnt == 3'd0) nxt = WR_HOLD; else cnt_nxt = cnt - 3'd1;
            WR_HOLD: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // state, request capture, read capture and pins all registered from the next state
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state           <= IDLE;
            cnt             <= 3'd0;
            be_q            <= 2'b00;
            SRAM_ADDR       <= '0;
            Data_to_SRAM    <= '0;
            rdata           <= '0;
            rdata_valid     <= 1'b0;
            SRAM_CE_N       <= 1'b1;
            SRAM_OE_N       <= 1'b1;
            SRAM_WE_N       <= 1'b1;
            SRAM_UB_N       <= 1'b1;
            SRAM_LB_N       <= 1'b1;
            Data_to_SRAM_oe <= 1'b0;
        end else begin
            state           <= nxt;
            cnt             <= cnt_nxt;
            be_q            <= be_nxt;
            if (acc) begin
                SRAM_ADDR    <= req_addr;
                Data_to_SRAM <= req_wdata;
            end
            rdata_valid     <= state == RD && cnt == 3'd0;
            if (state == RD && cnt == 3'd0) rdata <= Data_from_SRAM;
            SRAM_CE_N       <= nxt == IDLE;
            SRAM_OE_N       <= nxt != RD;
            SRAM_WE_N       <= !(nxt == WR_PULSE && |be_nxt);
            SRAM_UB_N       <= !(nxt == RD || (wr_nxt && be_nxt[1]));
            SRAM_LB_N       <= !(nxt == RD || (wr_nxt && be_nxt[0]));
            Data_to_SRAM_oe <= wr_nxt;
        end
    end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed checks of read/write timing for WAIT_CYCLES 1, 0 and 6
module tb_sram_ctrl;
    localparam int WS [3] = '{1, 0, 6};

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        req_valid, req_we;
    logic [19:0] req_addr;
    logic [15:0] req_wdata, dq;
    logic [1:0]  req_be;

    logic        rdy [3], rv [3], ce [3], oen [3], wen [3], ub [3], lb [3], oe [3];
    logic [15:0] rd [3], dts [3];
    logic [19:0] sa [3];

    int checks = 0, errors = 0, viol = 0;
    int lv [3], lr [3], nrv [3], noen [3], nwen [3], noe [3], nub [3], nlb [3];

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 3; g++) begin : u
        sram_ctrl #(.WAIT_CYCLES(WS[g])) dut (
            .Clk(Clk), .Reset_n(Reset_n), .req_valid(req_valid), .req_ready(rdy[g]),
            .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
            .rdata(rd[g]), .rdata_valid(rv[g]), .SRAM_ADDR(sa[g]),
            .SRAM_CE_N(ce[g]), .SRAM_OE_N(oen[g]), .SRAM_WE_N(wen[g]),
            .SRAM_UB_N(ub[g]), .SRAM_LB_N(lb[g]), .Data_to_SRAM(dts[g]),
            .Data_to_SRAM_oe(oe[g]), .Data_from_SRAM(dq)
        );
    end

    // bus-contention watch: OE_N and WE_N never low together, never drive DQ while SRAM drives it
    always @(negedge Clk)
        for (int k = 0; k < 3; k++)
            if (!oen[k] && (!wen[k] || oe[k])) viol++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic we, input logic [19:0] a, input logic [15:0] wd, input logic [1:0] be);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lv[k] = -1; lr[k] = -1; nrv[k] = 0; noen[k] = 0;
            nwen[k] = 0; noe[k] = 0; nub[k] = 0; nlb[k] = 0;
        end
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (rv[k] && lv[k] < 0) lv[k] = i;
                if (rdy[k] && lr[k] < 0) lr[k] = i;
                nrv[k]  += int'(rv[k]);
                noen[k] += int'(!oen[k]);
                nwen[k] += int'(!wen[k]);
                noe[k]  += int'(oe[k]);
                nub[k]  += int'(!ub[k]);
                nlb[k]  += int'(!lb[k]);
            end
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        Reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = 2'b00; dq = 16'hBEEF;
        repeat (2) @(posedge Clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_pins%0d", k), {ce[k], oen[k], wen[k], ub[k], lb[k], oe[k]}, 6'b111110);
            chk($sformatf("rst_ready%0d", k), rdy[k], 1'b1);
            chk($sformatf("rst_regs%0d", k), {sa[k], rd[k], dts[k], rv[k]}, 53'd0);
        end
        Reset_n = 1'b1;

        xfer(1'b0, 20'h12345, 16'h0000, 2'b11);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rd_lat%0d", k), lv[k], WS[k] + 1);
            chk($sformatf("rd_oen%0d", k), noen[k], WS[k] + 1);
            chk($sformatf("rd_pulses%0d", k), nrv[k], 1);
            chk($sformatf("rd_data%0d", k), rd[k], 16'hBEEF);
            chk($sformatf("rd_addr%0d", k), sa[k], 20'h12345);
            chk($sformatf("rd_noe%0d", k), noe[k], 0);
        end

        xfer(1'b1, 20'h00010, 16'hA5A5, 2'b11);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("wr_occ%0d", k), lr[k], WS[k] + 3);
            chk($sformatf("wr_wen%0d", k), nwen[k], WS[k] + 1);
            chk($sformatf("wr_oe%0d", k), noe[k], WS[k] + 3);
            chk($sformatf("wr_oen%0d", k), noen[k], 0);
            chk($sformatf("wr_ub%0d", k), nub[k] >= WS[k] + 2, 1'b1);
            chk($sformatf("wr_data%0d", k), {sa[k], dts[k]}, {20'h00010, 16'hA5A5});
            chk($sformatf("wr_nrv%0d", k), nrv[k], 0);
        end

        xfer(1'b1, 20'h00020, 16'h1234, 2'b10);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("be10_ub%0d", k), nub[k] >= WS[k] + 2, 1'b1);
            chk($sformatf("be10_lb%0d", k), nlb[k], 0);
            chk($sformatf("be10_wen%0d", k), nwen[k], WS[k] + 1);
        end

        xfer(1'b1, 20'h00030, 16'h5678, 2'b00);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("be00_wen%0d", k), nwen[k], 0);
            chk($sformatf("be00_occ%0d", k), lr[k], WS[k] + 3);
            chk($sformatf("be00_oe%0d", k), noe[k], WS[k] + 3);
        end

        // read held, then write held while busy: write must land in the rdata_valid cycle
        req_valid = 1'b1; req_we = 1'b0; req_addr = 20'h00444; req_be = 2'b11; dq = 16'h0F0F;
        @(posedge Clk); #1;
        req_we = 1'b1; req_addr = 20'h00555; req_wdata = 16'hC3C3;
        @(posedge Clk); #1;
        chk("b2b_still_rd", {oen[0], rdy[0]}, 2'b00);
        @(posedge Clk); #1;
        chk("b2b_valid", {rv[0], rdy[0], rd[0]}, {2'b11, 16'h0F0F});
        @(posedge Clk); #1;
        req_valid = 1'b0;
        chk("b2b_wr_accept", {oe[0], oen[0], ce[0], rdy[0], sa[0]}, {4'b1100, 20'h00555});
        repeat (16) @(posedge Clk);
        #1;

        // reset mid write pulse aborts the access asynchronously
        req_valid = 1'b1; req_we = 1'b1; req_addr = 20'h00777; req_wdata = 16'h9999; req_be = 2'b11;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        @(posedge Clk); #1;
        chk("rst_in_pulse", wen[0], 1'b0);
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_async", {wen[0], oe[0], ce[0], rdy[0]}, 4'b1011);
        @(posedge Clk); #1;
        chk("rst_held", {wen[0], oe[0], rv[0]}, 3'b100);
        Reset_n = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 20'h00888;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        chk("post_rst_accept", {oen[0], wen[0], rdy[0], sa[0]}, {3'b010, 20'h00888});
        repeat (12) @(posedge Clk);
        #1;
        chk("no_contention", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
